// File: rtl/serial_arith_pkg.sv
// Shared types and pin map for the bit-serial add/subtract engine.
package serial_arith_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   localparam int UI_A     = 0;
   localparam int UI_B     = 1;
   localparam int UI_VALID = 2;
   localparam int UI_SOF   = 3;
   localparam int UI_MODE  = 4;

   localparam int UO_RES   = 0;
   localparam int UO_CB    = 1;
   localparam int UO_VALID = 2;
   localparam int UO_DONE  = 3;
   localparam int UO_OVF   = 4;
   localparam int UO_BUSY  = 5;

endpackage

// File: rtl/serial_bit_alu.sv
// One-bit add/subtract cell; cin/cout carry the carry for add and the borrow for subtract.
module serial_bit_alu
   import serial_arith_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic mode,
   output logic r,
   output logic cout
);

   // sum/difference share the same xor; only the carry-out term differs
   always_comb begin
      r = a ^ b ^ cin;
      if (mode == MODE_ADD) begin
         cout = (a & b) | (cin & (a ^ b));
      end else begin
         cout = (~a & b) | (~(a ^ b) & cin);
      end
   end

endmodule

// File: rtl/tt_um_serial_addsub.sv
// Bit-serial add/subtract engine: LSB-first operand bits in, registered result bits
// out one cycle later, plus the assembled word, final carry/borrow and signed overflow.
module tt_um_serial_addsub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state_r;
   logic               mode_r;
   logic [CNT_W-1:0]   bit_cnt_r;
   logic [WIDTH-1:0]   shift_r;
   logic [WIDTH-1:0]   word_r;
   logic               res_bit_r;
   logic               cb_r;
   logic               res_valid_r;
   logic               word_done_r;
   logic               ovf_r;

   logic               a_s;
   logic               b_s;
   logic               take_s;
   logic               cur_mode_s;
   logic               cin_s;
   logic [CNT_W-1:0]   idx_s;
   logic               last_s;
   logic               alu_r_s;
   logic               alu_cout_s;
   logic               ovf_next_s;
   logic [WIDTH-1:0]   shift_next_s;
   logic [7:0]         uio_word_s;
   logic               unused_s;

   assign a_s      = ui_in[UI_A];
   assign b_s      = ui_in[UI_B];
   assign unused_s = ^{ui_in[7:5], uio_in};

   serial_bit_alu u_alu (
      .a    (a_s),
      .b    (b_s),
      .cin  (cin_s),
      .mode (cur_mode_s),
      .r    (alu_r_s),
      .cout (alu_cout_s)
   );

   // A sof bit always starts a fresh word (also aborting one in flight); other bits only count in RUN
   always_comb begin
      take_s = ena & ui_in[UI_VALID] & (ui_in[UI_SOF] | (state_r == RUN));
      if (ui_in[UI_SOF]) begin
         cur_mode_s = ui_in[UI_MODE];
         cin_s      = 1'b0;
         idx_s      = {CNT_W{1'b0}};
      end else begin
         cur_mode_s = mode_r;
         cin_s      = cb_r;
         idx_s      = bit_cnt_r;
      end
      last_s       = (idx_s == CNT_W'(WIDTH - 1));
      shift_next_s = {alu_r_s, shift_r[WIDTH-1:1]};
      if (cur_mode_s == MODE_ADD) begin
         ovf_next_s = (a_s == b_s) && (alu_r_s != a_s);
      end else begin
         ovf_next_s = (a_s != b_s) && (alu_r_s != a_s);
      end
   end

   // Zero-extend the completed word onto the bidirectional pins
   always_comb begin
      uio_word_s              = 8'h00;
      uio_word_s[WIDTH-1:0]   = word_r;
   end

   // FSM, bit counter, shift register and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mode_r      <= MODE_SUB;
         bit_cnt_r   <= {CNT_W{1'b0}};
         shift_r     <= {WIDTH{1'b0}};
         word_r      <= {WIDTH{1'b0}};
         res_bit_r   <= 1'b0;
         cb_r        <= 1'b0;
         res_valid_r <= 1'b0;
         word_done_r <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         res_valid_r <= 1'b0;
         word_done_r <= 1'b0;
         if (take_s) begin
            res_bit_r   <= alu_r_s;
            cb_r        <= alu_cout_s;
            res_valid_r <= 1'b1;
            mode_r      <= cur_mode_s;
            shift_r     <= shift_next_s;
            case (last_s)
               1'b1: begin
                  word_r      <= shift_next_s;
                  ovf_r       <= ovf_next_s;
                  word_done_r <= 1'b1;
                  bit_cnt_r   <= {CNT_W{1'b0}};
                  state_r     <= IDLE;
               end
               default: begin
                  bit_cnt_r   <= idx_s + CNT_W'(1);
                  state_r     <= RUN;
               end
            endcase
         end
      end
   end

   assign uo_out  = {2'b00, (state_r == RUN), ovf_r, word_done_r, res_valid_r, cb_r, res_bit_r};
   assign uio_out = uio_word_s;
   assign uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_serial_addsub.md
# tt_um_serial_addsub

Bit-serial add/subtract engine for the TinyTapeout user slot, the sequential counterpart of the single-bit half-adder tile. It accepts operand bit pairs LSB-first over the dedicated inputs and keeps a running carry or borrow. It streams each result bit out one cycle later and presents the assembled WIDTH-bit result word, final carry/borrow and signed overflow when the word completes.

## Interface
- WIDTH, 8, operand/result word length in bits; legal range 2..8.
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design enable; when low, inputs are ignored and all state holds.
- ui_in  input  8  [0] a bit; [1] b bit; [2] bit_valid; [3] sof (first/LSB bit of a word); [4] mode (0 = a−b, 1 = a+b); [7:5] ignored.
- uo_out  output  8  [0] res_bit; [1] cb (running carry for add, borrow for sub); [2] res_valid; [3] word_done; [4] ovf; [5] busy; [7:6] constant 0.
- uio_in  input  8  ignored.
- uio_out  output  8  result word, zero-extended above WIDTH.
- uio_oe  output  8  constant 8'hFF.

## Operation
- Accept condition: ena && bit_valid. The FSM has two states, IDLE and RUN.
- IDLE:
  - An accepted bit with sof=1 latches mode, forces the carry-in to 0 and processes bit 0. The FSM then enters RUN, or completes immediately if WIDTH were 1 (not legal).
  - An accepted bit with sof=0 in IDLE is dropped with no output.
- RUN:
  - Each accepted bit uses the registered cb as its carry-in and increments bit_cnt.
  - An accepted bit with sof=1 aborts the current word. That bit is processed as bit 0 of a new word, with mode re-latched, carry-in 0 and bit_cnt reset. No word_done is produced for the aborted word.
  - Bit WIDTH−1 accepted: go to IDLE.
- Add cell: s = a^b^c; c' = a&b | c&(a^b).
- Sub cell: d = a^b^c; c' = (~a&b) | (~(a^b)&c), where c is the borrow.
- Result bits shift into a WIDTH-bit shift register from the MSB side. After WIDTH bits, bit 0 holds the LSB.
- Signed overflow is evaluated on bit WIDTH−1 only:
  - add: ovf = (a==b) && (s!=a).
  - sub: ovf = (a!=b) && (d!=a).
- busy = (state==RUN).

## Timing
- Reset: all outputs except the constants go to 0; state IDLE; bit_cnt 0; shift register 0.
- Latency is 1 cycle: res_bit, cb and res_valid are registered and valid the cycle after an accepted bit.
- res_valid is high for exactly one cycle per accepted, non-dropped bit.
- res_bit and cb hold their values when no bit is accepted.
- word_done is a 1-cycle pulse in the same cycle as res_valid for bit WIDTH−1.
- uio_out and ovf update in that same cycle and hold until the next word completes. An aborted word does not disturb them.
- Gaps (bit_valid=0 or ena=0) may occur anywhere mid-word with no limit. State, count and carry hold across the gap.
- Back-to-back words are allowed: sof may arrive in the cycle right after the last bit, giving zero idle cycles.
- Reset mid-word clears everything asynchronously. The partial word is lost and no word_done is produced.

## Structure
- Package serial_arith_pkg holds:
  - the state enum {IDLE, RUN};
  - the MODE_SUB/MODE_ADD constants;
  - the ui_in/uo_out pin-index localparams.
- Sub-module serial_bit_alu: a combinational 1-bit add/sub cell with inputs a, b, cin, mode and outputs r, cout. Overflow logic stays in the top level.
- The top level holds the FSM, bit_cnt ($clog2(WIDTH) bits, wraps to 0 on completion), the shift register and the output registers.

## Test plan
- Sub 0x05−0x03, sent contiguously → eight res_valid pulses, uio_out=0x02, cb=0, ovf=0, one word_done.
- Sub 0x03−0x05 → uio_out=0xFE, cb=1, ovf=0.
- Sub 0x80−0x01 → uio_out=0x7F, ovf=1.
- Add 0xFF+0x01 → uio_out=0x00, cb=1, ovf=0.
- Add 0x7F+0x01 → uio_out=0x80, ovf=1.
- Add 0x12+0x34 with random bit_valid/ena gaps → 0x46 and word_done exactly once.
- A sof=0 bit in IDLE → no res_valid.
- sof mid-word after 3 bits, then a full 0x0A−0x04 → uio_out=0x06 with only one word_done.
- rst_n low after 4 bits → all outputs 0 immediately; the next full word computes correctly.
